dec_iter: RTL
=============

// Module: dec_iter
// PURPOSE
//  Iterative AES-128 inverse cipher; decryption counterpart of the enc block, using the same 1408-bit expanded-key format.
//  One round per clock: captures a 128-bit ciphertext on enable and returns plaintext with a one-cycle valid pulse 10 cycles later.
//  Sits beside enc in the cryptoprocessor datapath and shares the key-expansion output.
// PARAMETERS
//  NR      10   number of AES rounds; fixed for AES-128, other values unsupported
//  KEY_W   1408 expanded-key width = 128*(NR+1)
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     reset, asynchronous, active-low
//  enable      in   1     request: capture ciphertext when not busy
//  ciphertext  in   128   input block, byte 0 at [127:120]
//  exp_key     in   1408  round keys; rk0 at [1407:1280], rk10 at [127:0]
//  plaintext   out  128   decrypted block, registered
//  valid       out  1     one-cycle pulse: plaintext updated this cycle
//  busy        out  1     high while a block is in flight
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0, any time): plaintext=0, valid=0, busy=0, FSM=IDLE, round counter=0; an in-flight block is dropped with no valid.
//  FSM: IDLE -> RUN -> LAST -> IDLE.
//   IDLE: if enable at edge E0 -> state <= ciphertext ^ rk10, rnd <= 9, busy <= 1, go RUN.
//   RUN:  each edge, state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[rnd])).
//         rnd decrements; after the rnd=1 update go LAST.
//   LAST: plaintext <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0), valid <= 1, busy <= 0, go IDLE.
//  Latency: accept at E0; plaintext/valid registered at E10. valid high exactly one cycle (E10..E11).
//  enable while busy=1 ignored, not queued.
//  enable high during the valid cycle accepted at E11, so back-to-back period is 11 cycles.
//  ciphertext latched at accept; it may change or go X afterwards.
//  plaintext holds its value until the next LAST or reset.
//  rk[r] = exp_key[KEY_W-1-128*r -: 128]. InvMixColumns uses GF(2^8) mult by 0e/0b/0d/09 with poly 0x11b.
//  16 parallel inverse S-box lookups, combinational, single-cycle round path.
//  Without DEC_KEY_LATCH_EN, exp_key must stay stable from E0 through E10.
// CONFIGURATION
//  DEC_KEY_LATCH_EN defined:
//   - exp_key captured into an internal KEY_W register at accept; all rounds use the copy.
//   - Source may change exp_key immediately after E0.
//   - Key register resets to 0.
//  Not defined: no key register; exp_key read live each round (saves 1408 flops).
// TESTING
//  Expanded key for all vectors: 2b7e151628aed2a6abf7158809cf4f3c (SP800-38A); schedule as the enc bench uses.
//  1. ct 3ad77bb40d7a3660a89ecaf32466ef97 accepted at E0
//     -> valid at E10 only, plaintext 6bc1bee22e409f96e93d7e117393172a, busy 1 for E0..E10.
//  2. enable held high, ct f5d3d58503b9699de785895a96fdbaaf then 43b1cd7f598ece23881b00e3ed030688
//     -> second accepted at E11, pts ae2d8a571e03ac9c9eb76fac45af8e51 at E10, 30c81c46a35ce411e5fbc1191a0a52ef at E21.
//  3. enable pulses at E3, E7 while busy -> ignored, exactly one valid, ct 7b0c785e27e8ad3f8223207104725dd4 -> f69f2445df4f9b17ad2b417be66c3710.
//  4. ciphertext set to X after E0 -> correct plaintext still; rst_n low at E5 (async, mid-edge)
//     -> plaintext=0, busy=0, no valid; a new accept after release decrypts correctly.
//  5. DEC_KEY_LATCH_EN: exp_key zeroed at E1 -> test 1 result unchanged. Without the macro, same stimulus must not yield 6bc1...
//  6. Round-trip: feed 4 enc ciphertexts into dec_iter -> original plaintexts returned in order.

Source files
------------

// File: rtl/dec_iter_if.sv
// Bus bundle between the cryptoprocessor datapath and the dec_iter block.
// Handshake: enable requests a capture and is honoured only while busy is low;
// valid is a one-cycle pulse meaning plaintext was updated on that edge. No backpressure.
interface dec_iter_if #(
  parameter int KEY_W = 1408
);
  logic             enable;
  logic [127:0]     ciphertext;
  logic [KEY_W-1:0] exp_key;
  logic [127:0]     plaintext;
  logic             valid;
  logic             busy;

  modport master (
    output enable, ciphertext, exp_key,
    input  plaintext, valid, busy
  );

  modport slave (
    input  enable, ciphertext, exp_key,
    output plaintext, valid, busy
  );
endinterface

// File: rtl/dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, sharing the enc expanded-key format.
// Optional macro DEC_KEY_LATCH_EN: capture exp_key at accept so the source may change afterwards.
module dec_iter #(
  parameter int NR    = 10,
  parameter int KEY_W = 1408
) (
  input  logic       clk,
  input  logic       rst_n,
  dec_iter_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_e;

  localparam logic [3:0] RND_LAST  = 4'(NR);
  localparam logic [3:0] RND_START = 4'(NR - 1);

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_e       state_q, state_d;
  logic [3:0]   rnd_q,   rnd_d;
  logic [127:0] blk_q,   blk_d;
  logic [127:0] pt_q,    pt_d;
  logic         valid_q, valid_d;
  logic         busy_q,  busy_d;
  logic [KEY_W-1:0] key_w;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at [127-8i -: 8]; bytes are column-major (row r, column c is byte r+4c).
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r) & 3)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m2 [4];
    logic [7:0]   m4 [4];
    logic [7:0]   m8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8*(r + 4*c) -: 8];
        m2[r] = xt(a[r]);
        m4[r] = xt(m2[r]);
        m8[r] = xt(m4[r]);
        m9[r] = m8[r] ^ a[r];
        mb[r] = m8[r] ^ m2[r] ^ a[r];
        md[r] = m8[r] ^ m4[r] ^ a[r];
        me[r] = m8[r] ^ m4[r] ^ m2[r];
      end
      o[127 - 8*(4*c)     -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127 - 8*(4*c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127 - 8*(4*c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127 - 8*(4*c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  function automatic logic [127:0] rk(input logic [KEY_W-1:0] k, input logic [3:0] r);
    return k[(KEY_W - 1) - 128*int'(r) -: 128];
  endfunction

`ifdef DEC_KEY_LATCH_EN
  logic [KEY_W-1:0] key_q, key_d;

  // The accepting edge still reads the live key; later rounds use the captured copy.
  assign key_w = (state_q == S_IDLE) ? bus.exp_key : key_q;
  assign key_d = (state_q == S_IDLE && bus.enable) ? bus.exp_key : key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= '0;
    else        key_q <= key_d;
  end
`else
  assign key_w = bus.exp_key;
`endif

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    pt_d    = pt_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          blk_d   = bus.ciphertext ^ rk(key_w, RND_LAST);
          rnd_d   = RND_START;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        blk_d = inv_mix(inv_sub_shift(blk_q) ^ rk(key_w, rnd_q));
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = S_LAST;
      end
      S_LAST: begin
        pt_d    = inv_sub_shift(blk_q) ^ rk(key_w, 4'd0);
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      pt_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      pt_q    <= pt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.plaintext = pt_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign dbg_state_o   = state_q;

endmodule
